// File: rtl/mealy_pkg.sv
// Shared FSM-lab definitions: event-select mode encodings and the event decode
// used by the Mealy modulo detector.
package mealy_pkg;

   localparam logic [1:0] MODE_ONES  = 2'b00;
   localparam logic [1:0] MODE_ZEROS = 2'b01;
   localparam logic [1:0] MODE_RISE  = 2'b10;
   localparam logic [1:0] MODE_FALL  = 2'b11;

   // Edges are judged against the previous clock's input sample.
   function automatic logic event_of(input logic [1:0] mode,
                                     input logic       cur,
                                     input logic       prev);
      logic ev;
      ev = 1'b0;
      case (mode)
         MODE_ONES:  ev = cur;
         MODE_ZEROS: ev = !cur;
         MODE_RISE:  ev = cur & !prev;
         MODE_FALL:  ev = !cur & prev;
         default:    ev = 1'b0;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/mealy_event_sel.sv
// Event selector: tracks the previous input sample and decodes the raw event
// for the requested mode. Qualification (enable, mode stability) is done above.
module mealy_event_sel
   import mealy_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   input  logic [1:0] mode,
   output logic       ev
);

   logic prev_in;

   // prev_in tracks every cycle, even when events are disabled upstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_in <= 1'b0;
      end else begin
         prev_in <= in;
      end
   end

   assign ev = event_of(mode, in, prev_in);

endmodule

// File: rtl/mealy_mod_detector.sv
// Mealy modulo-MOD event counter: residue FSM with a same-cycle completion flag,
// its registered copy, and a saturating count of completions.
module mealy_mod_detector
   import mealy_pkg::*;
#(
   parameter  int MOD   = 3,
   parameter  int CNT_W = 8,
   localparam int RW    = $clog2(MOD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in,
   input  logic [1:0]       mode,
   output logic             out,
   output logic             out_q,
   output logic [RW-1:0]    residue,
   output logic [CNT_W-1:0] wraps,
   output logic             sat
);

   localparam logic [RW-1:0] RES_MAX = RW'(MOD - 1);

   logic       ev;
   logic [1:0] mode_q;
   logic       mode_chg;
   logic       qev;
   logic       at_max;

   mealy_event_sel u_event_sel (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .mode (mode),
      .ev   (ev)
   );

   // A mode switch swallows that cycle's event; reset always wins.
   assign mode_chg = (mode != mode_q);
   assign qev      = en & ev & !mode_chg & !rst;
   assign at_max   = (residue == RES_MAX);
   assign out      = qev & at_max;
   assign sat      = &wraps;

   always_ff @(posedge clk) begin
      if (rst) begin
         residue <= '0;
         mode_q  <= MODE_ONES;
         out_q   <= 1'b0;
         wraps   <= '0;
      end else begin
         out_q <= out;
         if (mode_chg) begin
            residue <= '0;
            mode_q  <= mode;
         end else if (qev) begin
            residue <= at_max ? '0 : residue + 1'b1;
         end
         if (out && !sat) begin
            wraps <= wraps + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mealy_mod_detector.sv
// Bench for mealy_mod_detector: four parameterisations share one stimulus bus;
// each vector names the instance it checks.
module tb_mealy_mod_detector;

   typedef struct {
      int         sel;
      logic       rst;
      logic       en;
      logic       in;
      logic [1:0] mode;
      logic       exp_out;
      logic [7:0] exp_res;
      logic [7:0] exp_wraps;
      logic       exp_sat;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       in_s;
   logic [1:0] mode;

   logic       out3, outq3, sat3;
   logic [1:0] res3;
   logic [7:0] wr3;
   logic       out5, outq5, sat5;
   logic [2:0] res5;
   logic [7:0] wr5;
   logic       out4, outq4, sat4;
   logic [1:0] res4;
   logic [7:0] wr4;
   logic       out2, outq2, sat2;
   logic [0:0] res2;
   logic [1:0] wr2;

   int         sel;
   logic       out_m, outq_m, sat_m;
   logic [7:0] res_m, wraps_m;

   int         checks;
   int         failures;
   logic [0:0] exp_q[$];
   vec_t       vecs[$];

   mealy_mod_detector #(.MOD(3), .CNT_W(8)) u3 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .mode(mode),
      .out(out3), .out_q(outq3), .residue(res3), .wraps(wr3), .sat(sat3));
   mealy_mod_detector #(.MOD(5), .CNT_W(8)) u5 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .mode(mode),
      .out(out5), .out_q(outq5), .residue(res5), .wraps(wr5), .sat(sat5));
   mealy_mod_detector #(.MOD(4), .CNT_W(8)) u4 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .mode(mode),
      .out(out4), .out_q(outq4), .residue(res4), .wraps(wr4), .sat(sat4));
   mealy_mod_detector #(.MOD(2), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .mode(mode),
      .out(out2), .out_q(outq2), .residue(res2), .wraps(wr2), .sat(sat2));

   always_comb begin
      out_m   = 1'b0;
      outq_m  = 1'b0;
      sat_m   = 1'b0;
      res_m   = 8'd0;
      wraps_m = 8'd0;
      case (sel)
         3: begin out_m = out3; outq_m = outq3; sat_m = sat3; res_m = 8'(res3); wraps_m = wr3; end
         5: begin out_m = out5; outq_m = outq5; sat_m = sat5; res_m = 8'(res5); wraps_m = wr5; end
         4: begin out_m = out4; outq_m = outq4; sat_m = sat4; res_m = 8'(res4); wraps_m = wr4; end
         2: begin out_m = out2; outq_m = outq2; sat_m = sat2; res_m = 8'(res2); wraps_m = 8'(wr2); end
         default: ;
      endcase
   end

   // Clock / reset defaults
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input int s, input logic r, input logic e, input logic i,
                               input logic [1:0] m, input logic eo, input int er,
                               input int ew, input logic es);
      vec_t v;
      v.sel = s; v.rst = r; v.en = e; v.in = i; v.mode = m;
      v.exp_out = eo; v.exp_res = 8'(er); v.exp_wraps = 8'(ew); v.exp_sat = es;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver: apply one vector just after a rising edge, check the Mealy output
   // mid-cycle, then the registered outputs just after the next edge.
   task automatic run_vec(input vec_t v, input string tag);
      logic [0:0] eq;
      sel  = v.sel;
      rst  = v.rst;
      en   = v.en;
      in_s = v.in;
      mode = v.mode;
      exp_q.push_back(v.exp_out);
      @(negedge clk);
      check({tag, " out"}, 8'(out_m), 8'(v.exp_out));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s out_q: scoreboard empty got %0h expected entry", tag, outq_m);
      end else begin
         eq = exp_q.pop_front();
         check({tag, " out_q"}, 8'(outq_m), 8'(eq));
      end
      check({tag, " residue"}, res_m, v.exp_res);
      check({tag, " wraps"}, wraps_m, v.exp_wraps);
      check({tag, " sat"}, 8'(sat_m), 8'(v.exp_sat));
   endtask

   initial begin
      int n;
      int rises;
      logic e, i;
      checks   = 0;
      failures = 0;
      sel  = 3;
      rst  = 1'b1;
      en   = 1'b0;
      in_s = 1'b0;
      mode = 2'b00;
      @(posedge clk);
      #1;

      // Three-state instance, ones: 1,1,1,0,1,1,1
      vecs.push_back(mk(3, 1, 0, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 1, 0, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 2, 0, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 1, 0, 1, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b00, 0, 0, 1, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 1, 1, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 2, 1, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 1, 0, 2, 0));
      // Three-state instance: mode switch 00->01 at residue 2, then three zeros
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 1, 2, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 2, 2, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b01, 0, 0, 2, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b01, 0, 1, 2, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b01, 0, 2, 2, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b01, 1, 0, 3, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b01, 0, 1, 3, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 0, 3, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 1, 3, 0));
      vecs.push_back(mk(3, 0, 0, 1, 2'b00, 0, 1, 3, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b00, 0, 2, 3, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b01, 0, 0, 3, 0));
      // Three-state instance: falling edge masked by en low
      vecs.push_back(mk(3, 1, 0, 0, 2'b11, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b11, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b11, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 0, 0, 2'b11, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b11, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 1, 1, 2'b11, 0, 0, 0, 0));
      vecs.push_back(mk(3, 0, 1, 0, 2'b11, 0, 1, 0, 0));
      // Four-state instance: reset colliding with an event at residue 3
      vecs.push_back(mk(4, 1, 0, 0, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 1, 0, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 2, 0, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 3, 0, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 1, 0, 1, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 1, 1, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 2, 1, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 3, 1, 0));
      vecs.push_back(mk(4, 1, 1, 1, 2'b00, 0, 0, 0, 0));
      vecs.push_back(mk(4, 0, 1, 1, 2'b00, 0, 1, 0, 0));

      foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Five-state instance: rising edges, in toggling from 0 for 20 cycles
      run_vec(mk(5, 1, 0, 0, 2'b10, 0, 0, 0, 0), "rise rst");
      for (int c = 1; c <= 20; c++) begin
         rises = c / 2;
         run_vec(mk(5, 0, 1, logic'(c % 2 == 0), 2'b10,
                    logic'((c % 2 == 0) && (rises % 5 == 0)), rises % 5, rises / 5, 0),
                 $sformatf("rise c%0d", c));
      end

      // Five-state instance: zeros under random en/in
      run_vec(mk(5, 1, 0, 0, 2'b01, 0, 0, 0, 0), "rnd rst");
      run_vec(mk(5, 0, 1, 0, 2'b01, 0, 0, 0, 0), "rnd modechg");
      n = 0;
      for (int c = 0; c < 40; c++) begin
         e = logic'($urandom_range(0, 3) != 0);
         i = logic'($urandom_range(0, 1));
         if (e && !i) n++;
         run_vec(mk(5, 0, e, i, 2'b01, logic'(e && !i && (n % 5 == 0)), n % 5, n / 5, 0),
                 $sformatf("rnd c%0d", c));
      end

      // Two-state instance with a 2-bit counter: saturation while out keeps pulsing
      run_vec(mk(2, 1, 0, 0, 2'b00, 0, 0, 0, 0), "sat rst");
      for (int c = 1; c <= 10; c++) begin
         run_vec(mk(2, 0, 1, 1, 2'b00, logic'(c % 2 == 0), c % 2,
                    (c / 2 > 3) ? 3 : c / 2, logic'(c / 2 >= 3)),
                 $sformatf("sat c%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mealy_mod_detector.md
# mealy_mod_detector

Parametrised Mealy-machine event counter. Counts qualifying events on a serial input modulo `MOD` and flags, in the same cycle, the event that completes each multiple of `MOD`. Event selection is runtime and covers four modes: ones, zeros, rising edges, falling edges. Sits in the FSM lab datapath as a generic divisibility/sequence detector, replacing the fixed mod-3 ones detector.

## Interface
- `MOD`, default 3: modulus, number of residue states; legal range 2..256.
- `CNT_W`, default 8: width of the saturating completion counter.
- `RW` (localparam): `$clog2(MOD)`, residue width.

Ports (clk and rst first):
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: event qualify enable.
- `in`  in  1: serial data input.
- `mode`  in  2: event select. 00 ones, 01 zeros, 10 rising edge, 11 falling edge.
- `out`  out  1: Mealy output (combinational), high in the cycle whose event completes a multiple of `MOD`.
- `out_q`  out  1: `out` registered one cycle.
- `residue`  out  RW: current state, event count mod `MOD`.
- `wraps`  out  CNT_W: number of completions since reset, saturating.
- `sat`  out  1: high when `wraps` is all-ones.

## Operation
- State register `residue` takes values 0..MOD-1, giving MOD states S0..S(MOD-1) and generalising Q0/Q1/Q2.
- `prev_in` register holds last-cycle `in`. It updates every non-reset cycle regardless of `en`.
- `mode_q` register holds the mode in force.
- Event `ev`:
  - mode 00: `in`
  - mode 01: `!in`
  - mode 10: `in & !prev_in`
  - mode 11: `!in & prev_in`
- Qualified event is `qev = en & ev & (mode == mode_q) & !rst`.
- Transition on `qev`: residue becomes residue+1, or 0 when residue == MOD-1 (wrap). With no `qev`, residue holds.
- `out = qev & (residue == MOD-1)`. This is a Mealy output and depends on current `in`.
- On `out`, `wraps` increments unless all-ones, where it holds. `sat = &wraps`.
- Mode change (`mode != mode_q`):
  - that cycle's event is suppressed;
  - residue clears to 0;
  - `mode_q` takes `mode`;
  - `wraps` is unaffected;
  - counting resumes next cycle under the new mode.
- Reset values: `residue` 0, `prev_in` 0, `mode_q` 00, `out_q` 0, `wraps` 0, `sat` 0. `out` is forced 0 while `rst` is high.
- Reset asserted mid-count discards the residue. The first event after reset counts as event 1.

## Timing
- `out` has zero latency: it is valid in the same cycle as `in`/`en`, so sample it before the clock edge.
- `out_q`, `residue`, `wraps` and `sat` reflect an event one cycle later.
- Edge modes: an edge is defined against the previous clock's `in`. After reset, `prev_in` = 0, so `in` = 1 in the first cycle is a rising edge.
- `en` low does not block `prev_in` tracking. An edge that straddles a disabled cycle is therefore not counted later.
- Simultaneous `rst` and event: reset wins, and no count or output occurs.
- Simultaneous mode change and event: the event is dropped and residue goes to 0.
- `wraps` at saturation: `out` still pulses; `wraps` holds at all-ones.

## Structure
- Package `mealy_pkg`: mode constants `MODE_ONES`, `MODE_ZEROS`, `MODE_RISE`, `MODE_FALL` (2-bit), shared with other FSM lab blocks.
- Sub-module `mealy_event_sel`: owns `prev_in` and the mode mux, and outputs `ev`.
- The top module holds the residue FSM, `mode_q`, the completion counter and `out_q`.

## Test plan
- MOD=3, mode 00, en=1, `in` = 1,1,1,0,1,1,1 → `out` high on the 3rd and 7th cycles; residue sequence 1,2,0,0,1,2,0; `wraps` = 2.
- MOD=5, mode 10, `in` toggles 0/1 each cycle for 20 cycles → 10 rising edges; `out` high on the 5th and 10th rising edges; residue 0 at end.
- MOD=3, residue=2, `mode` switched 00→01 while `in`=1 → no `out`, residue 0, `mode_q`=01; three following zeros → `out` on the third.
- MOD=4, residue=3, `rst` high in the same cycle as `in`=1 → `out`=0, all outputs at reset values next cycle; first subsequent event gives residue 1.
- CNT_W=2, MOD=2, mode 00, `in`=1 for 10 cycles → `out` pulses on every 2nd cycle; `wraps` saturates at 3 with `sat`=1 after the 3rd completion, and `out` keeps pulsing.
- mode 11, `en` low across a falling edge then high → edge not counted; residue unchanged.
